// File: rtl/frame_dispatch.sv
// Egress receiver for the switch-core forwarding stream: parses the 2-byte header,
// fans frame bytes out to the admitted per-port data FIFOs, then pushes one pointer word per port.

module frame_dispatch_port #(
    parameter int SPACE_W   = 12,
    parameter int BP_THRESH = 1600
) (
    input  logic [SPACE_W-1:0] space_i,
    input  logic               ptr_full_i,
    input  logic               pmap_i,
    input  logic [11:0]        len_i,
    output logic               admit_o,
    output logic               bp_o
);
    localparam int            CW    = (SPACE_W > 12) ? SPACE_W : 12;
    localparam logic [CW-1:0] BP_TH = CW'(BP_THRESH);

    logic [CW-1:0] space_w, len_w;

    assign space_w = CW'(space_i);
    assign len_w   = CW'(len_i);
    assign admit_o = pmap_i & ~ptr_full_i & (space_w >= len_w);
    assign bp_o    = (space_w < BP_TH) | ptr_full_i;
endmodule

module frame_dispatch #(
    parameter int MAX_LEN   = 1536,
    parameter int BP_THRESH = 1600,
    parameter int SPACE_W   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sof,
    input  logic                 dv,
    input  logic [7:0]           data,
    input  logic [4*SPACE_W-1:0] q_space,
    input  logic [3:0]           ptr_full,
    output logic [3:0]           q_wr,
    output logic [7:0]           q_din,
    output logic [3:0]           ptr_wr,
    output logic [15:0]          ptr_din,
    output logic                 bp0,
    output logic                 bp1,
    output logic                 bp2,
    output logic                 bp3,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          drop_cnt
);
    localparam logic [11:0] MAX_L = 12'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, HDR1, DATA, COMMIT, DROP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  pmap_q, pmap_d, len_hi_q, len_hi_d, mask_q, mask_d;
    logic [11:0] len_q, len_d, cnt_q, cnt_d;
    logic        trunc_q, trunc_d, pend_q, pend_d;
    logic [3:0]  q_wr_q, q_wr_d, ptr_wr_q, ptr_wr_d, bp_q, bp_d;
    logic [7:0]  q_din_q, q_din_d;
    logic [15:0] ptr_din_q, ptr_din_d, frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

    logic [11:0] hdr_len;
    logic [3:0]  admit, bp_now;

    assign hdr_len = {len_hi_q, data};

    for (genvar g = 0; g < 4; g++) begin : g_port
        frame_dispatch_port #(.SPACE_W(SPACE_W), .BP_THRESH(BP_THRESH)) u_port (
            .space_i    (q_space[g*SPACE_W +: SPACE_W]),
            .ptr_full_i (ptr_full[g]),
            .pmap_i     (pmap_q[g]),
            .len_i      (hdr_len),
            .admit_o    (admit[g]),
            .bp_o       (bp_now[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        pmap_d      = pmap_q;
        len_hi_d    = len_hi_q;
        mask_d      = mask_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        trunc_d     = trunc_q;
        pend_d      = pend_q;
        q_wr_d      = '0;
        q_din_d     = q_din_q;
        ptr_wr_d    = '0;
        ptr_din_d   = ptr_din_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        bp_d        = bp_now;
        case (state_q)
            IDLE: begin
                if (sof && dv) begin
                    pmap_d   = data[3:0];
                    len_hi_d = data[7:4];
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (!dv) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d    = IDLE;
                end else begin
                    len_d   = hdr_len;
                    mask_d  = admit;
                    cnt_d   = '0;
                    trunc_d = 1'b0;
                    if (hdr_len == '0 || hdr_len > MAX_L || admit == '0) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                        pend_d     = 1'b0;
                        state_d    = DROP;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // End of stream or a new sof: the pointer is registered now so it
                // lands in the cycle right after the last data write.
                if (!dv || sof) begin
                    trunc_d     = dv;
                    ptr_wr_d    = mask_q;
                    ptr_din_d   = {(cnt_q != len_q) | dv, 3'b000, cnt_q};
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = COMMIT;
                end else if (cnt_q < len_q) begin
                    q_wr_d  = mask_q;
                    q_din_d = data;
                    cnt_d   = cnt_q + 12'd1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (trunc_q) begin
                    if (dv) begin
                        pend_d  = 1'b1;
                        state_d = DROP;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
            end
            DROP: begin
                if (!dv) begin
                    if (pend_q) drop_cnt_d = drop_cnt_q + 16'd1;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pmap_q      <= '0;
            len_hi_q    <= '0;
            mask_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            pend_q      <= 1'b0;
            q_wr_q      <= '0;
            q_din_q     <= '0;
            ptr_wr_q    <= '0;
            ptr_din_q   <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            bp_q        <= '0;
        end else begin
            state_q     <= state_d;
            pmap_q      <= pmap_d;
            len_hi_q    <= len_hi_d;
            mask_q      <= mask_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            trunc_q     <= trunc_d;
            pend_q      <= pend_d;
            q_wr_q      <= q_wr_d;
            q_din_q     <= q_din_d;
            ptr_wr_q    <= ptr_wr_d;
            ptr_din_q   <= ptr_din_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            bp_q        <= bp_d;
        end
    end

    assign q_wr      = q_wr_q;
    assign q_din     = q_din_q;
    assign ptr_wr    = ptr_wr_q;
    assign ptr_din   = ptr_din_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign {bp3, bp2, bp1, bp0} = bp_q;
endmodule

// File: tb/tb_frame_dispatch.sv
// Directed bench for frame_dispatch: header parse, fan-out, padding, admission,
// short/truncated frames, reset mid-frame and backpressure.

module tb_frame_dispatch;
    logic        clk = 1'b0;
    logic        rst, sof, dv;
    logic [7:0]  data;
    logic [47:0] q_space;
    logic [3:0]  ptr_full;
    logic [3:0]  q_wr, ptr_wr;
    logic [7:0]  q_din;
    logic [15:0] ptr_din, frame_cnt, drop_cnt;
    logic        bp0, bp1, bp2, bp3;

    int n_cmp = 0;
    int n_bad = 0;

    frame_dispatch dut (
        .clk(clk), .rst(rst), .sof(sof), .dv(dv), .data(data),
        .q_space(q_space), .ptr_full(ptr_full),
        .q_wr(q_wr), .q_din(q_din), .ptr_wr(ptr_wr), .ptr_din(ptr_din),
        .bp0(bp0), .bp1(bp1), .bp2(bp2), .bp3(bp3),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic d, input logic [7:0] b);
        sof  = s;
        dv   = d;
        data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic set_space(input int p, input logic [11:0] v);
        q_space[p*12 +: 12] = v;
    endtask

    // Sends a header plus nb bytes (values 0,1,2..), then drops dv.
    // emask==0 means the frame must be dropped without any writes.
    task automatic frame(input logic [7:0] h0, input logic [7:0] h1, input int nb,
                         input logic [3:0] emask, input int nwr, input logic [15:0] eptr);
        drive(1'b1, 1'b1, h0);
        chk("hdr0_qwr", 32'(q_wr), 32'h0);
        drive(1'b0, 1'b1, h1);
        chk("hdr1_qwr", 32'(q_wr), 32'h0);
        for (int i = 0; i < nb; i++) begin
            drive(1'b0, 1'b1, 8'(i));
            chk("data_qwr", 32'(q_wr), (i < nwr) ? 32'(emask) : 32'h0);
            if (i < nwr && emask != 4'h0) chk("data_qdin", 32'(q_din), 32'(i[7:0]));
        end
        drive(1'b0, 1'b0, 8'h00);
        chk("commit_ptrwr", 32'(ptr_wr), 32'(emask));
        chk("commit_qwr", 32'(q_wr), 32'h0);
        if (emask != 4'h0) chk("commit_ptrdin", 32'(ptr_din), 32'(eptr));
        drive(1'b0, 1'b0, 8'h00);
        chk("post_ptrwr", 32'(ptr_wr), 32'h0);
    endtask

    initial begin
        rst = 1'b1; sof = 1'b0; dv = 1'b0; data = 8'h00;
        q_space = {4{12'd2000}};
        ptr_full = 4'h0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        chk("rst_qwr", 32'(q_wr), 32'h0);
        chk("rst_ptrwr", 32'(ptr_wr), 32'h0);
        chk("rst_ptrdin", 32'(ptr_din), 32'h0);
        chk("rst_qdin", 32'(q_din), 32'h0);
        chk("rst_bp", 32'({bp3, bp2, bp1, bp0}), 32'h0);
        chk("rst_fcnt", 32'(frame_cnt), 32'h0);
        chk("rst_dcnt", 32'(drop_cnt), 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);

        // unicast: len 64 to port 1
        frame(8'h02, 8'h40, 64, 4'b0010, 64, 16'h0040);
        chk("uni_fcnt", 32'(frame_cnt), 32'd1);

        // broadcast with 4 pad bytes
        frame(8'h0E, 8'h3C, 64, 4'b1110, 60, 16'h003C);
        chk("bc_fcnt", 32'(frame_cnt), 32'd2);

        // admission: port 2 lacks space
        set_space(2, 12'd40);
        frame(8'h06, 8'h40, 64, 4'b0010, 64, 16'h0040);
        chk("adm_bp2", 32'(bp2), 32'h1);
        frame(8'h04, 8'h40, 8, 4'b0000, 0, 16'h0000);
        chk("adm_dcnt", 32'(drop_cnt), 32'd1);
        chk("adm_fcnt", 32'(frame_cnt), 32'd3);
        set_space(2, 12'd2000);

        // short frame: len 100, 70 bytes
        frame(8'h01, 8'h64, 70, 4'b0001, 70, 16'h8046);
        chk("short_fcnt", 32'(frame_cnt), 32'd4);

        // truncation at byte 30 of a len-64 frame
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b0, 1'b1, 8'h40);
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 1'b1, 8'(i));
            chk("tr_qwr", 32'(q_wr), 32'h1);
        end
        drive(1'b1, 1'b1, 8'h02);
        chk("tr_ptrwr", 32'(ptr_wr), 32'h1);
        chk("tr_ptrdin", 32'(ptr_din), 32'h801E);
        chk("tr_qwr0", 32'(q_wr), 32'h0);
        chk("tr_fcnt", 32'(frame_cnt), 32'd5);
        drive(1'b0, 1'b1, 8'h40);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 8'(i));
            chk("tr_drop_qwr", 32'({q_wr, ptr_wr}), 32'h0);
        end
        chk("tr_dcnt_hold", 32'(drop_cnt), 32'd1);
        drive(1'b0, 1'b0, 8'h00);
        chk("tr_dcnt", 32'(drop_cnt), 32'd2);
        drive(1'b0, 1'b0, 8'h00);
        frame(8'h02, 8'h10, 16, 4'b0010, 16, 16'h0010);
        chk("tr_next_fcnt", 32'(frame_cnt), 32'd6);

        // length boundaries: 1537 and 0 are dropped
        frame(8'h61, 8'h01, 4, 4'b0000, 0, 16'h0000);
        chk("max_dcnt", 32'(drop_cnt), 32'd3);
        frame(8'h01, 8'h00, 4, 4'b0000, 0, 16'h0000);
        chk("zero_dcnt", 32'(drop_cnt), 32'd4);
        chk("bnd_fcnt", 32'(frame_cnt), 32'd6);

        // reset mid-DATA at byte 10
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b0, 1'b1, 8'h40);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'(i));
        chk("mid_qwr_pre", 32'(q_wr), 32'h1);
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h0A);
        chk("mid_qwr", 32'(q_wr), 32'h0);
        chk("mid_ptrwr", 32'(ptr_wr), 32'h0);
        chk("mid_ptrdin", 32'(ptr_din), 32'h0);
        chk("mid_fcnt", 32'(frame_cnt), 32'h0);
        chk("mid_dcnt", 32'(drop_cnt), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h55);
            chk("mid_trail_qwr", 32'(q_wr), 32'h0);
        end
        drive(1'b0, 1'b0, 8'h00);
        chk("mid_trail_ptrwr", 32'(ptr_wr), 32'h0);
        chk("mid_trail_fcnt", 32'(frame_cnt), 32'h0);

        // backpressure thresholds
        set_space(3, 12'd1599);
        drive(1'b0, 1'b0, 8'h00);
        chk("bp3_1599", 32'(bp3), 32'h1);
        set_space(3, 12'd1600);
        drive(1'b0, 1'b0, 8'h00);
        chk("bp3_1600", 32'(bp3), 32'h0);
        ptr_full = 4'b0001;
        drive(1'b0, 1'b0, 8'h00);
        chk("bp_full", 32'({bp3, bp2, bp1, bp0}), 32'h1);
        ptr_full = 4'b0000;
        drive(1'b0, 1'b0, 8'h00);
        chk("bp_clear", 32'({bp3, bp2, bp1, bp0}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
